// File: rtl/raifes_dm_regaccess.sv
// rtl/raifes_dm_regaccess.sv - debug-module initiator for the register file debug port
// Executes RISC-V "Access Register" abstract commands issued over DMI (data0,
// abstractcs, command). Optional macro DM_AUTOEXEC_EN adds abstractauto at 0x18.
module raifes_dm_regaccess #(
  parameter int XLEN    = 32,
  parameter int NUM_GPR = 32,
  parameter int AW      = 5
) (
  input  logic            clk,
  input  logic            nreset,
  input  logic            dmi_req_valid,
  output logic            dmi_req_ready,
  input  logic [6:0]      dmi_req_addr,
  input  logic            dmi_req_wr,
  input  logic [XLEN-1:0] dmi_req_wdata,
  output logic            dmi_resp_valid,
  input  logic            dmi_resp_ready,
  output logic [XLEN-1:0] dmi_resp_rdata,
  input  logic            hart_halted,
  output logic [AW-1:0]   dm_wara,
  output logic [XLEN-1:0] dm_wd,
  output logic            dm_wen,
  input  logic [XLEN-1:0] dm_rd
);

  localparam logic [6:0]  ADDR_DATA0 = 7'h04;
  localparam logic [6:0]  ADDR_ACS   = 7'h16;
  localparam logic [6:0]  ADDR_CMD   = 7'h17;
  localparam logic [6:0]  ADDR_AUTO  = 7'h18;
  localparam logic [15:0] GPR_BASE   = 16'h1000;
  localparam logic [15:0] GPR_LIMIT  = 16'(32'h1000 + NUM_GPR);

  typedef enum logic [1:0] {S_IDLE, S_READ, S_WRITE} state_t;

  state_t            state_q, state_d;
  logic [XLEN-1:0]   data0_q, data0_d;
  logic [2:0]        cmderr_q, cmderr_d;
  logic              resp_valid_q, resp_valid_d;
  logic [XLEN-1:0]   resp_rdata_q, resp_rdata_d;
  logic [AW-1:0]     dm_wara_q, dm_wara_d;

  logic              busy, req_fire;
  logic              wr_data0, rd_data0, wr_acs, wr_cmd, wr_auto;
  logic              auto_on;
  logic              exec_go;
  logic [XLEN-1:0]   exec_word;
  logic [15:0]       regno;
  logic              in_range, bad_fields;
  logic [2:0]        err_set;
  logic              launch, launch_wr;
  logic [XLEN-1:0]   rdata_mux;
  logic              unused_bits;

`ifdef DM_AUTOEXEC_EN
  logic              autoexec_q, autoexec_d;
  logic [XLEN-1:0]   cmd_q, cmd_d;
  logic              pend_q, pend_d;
  assign auto_on   = autoexec_q;
  // a pending re-execution runs the stored word; DMI is blocked that cycle
  assign exec_go   = wr_cmd | pend_q;
  assign exec_word = wr_cmd ? dmi_req_wdata : cmd_q;
`else
  assign auto_on   = 1'b0;
  assign exec_go   = wr_cmd;
  assign exec_word = dmi_req_wdata;
`endif

  assign busy          = (state_q != S_IDLE);
  assign dmi_req_ready = !resp_valid_q;
  assign req_fire      = dmi_req_valid & dmi_req_ready;
  assign wr_data0      = req_fire &  dmi_req_wr & (dmi_req_addr == ADDR_DATA0);
  assign rd_data0      = req_fire & !dmi_req_wr & (dmi_req_addr == ADDR_DATA0);
  assign wr_acs        = req_fire &  dmi_req_wr & (dmi_req_addr == ADDR_ACS);
  assign wr_cmd        = req_fire &  dmi_req_wr & (dmi_req_addr == ADDR_CMD);
  assign wr_auto       = req_fire &  dmi_req_wr & (dmi_req_addr == ADDR_AUTO);

  assign regno       = exec_word[15:0];
  assign in_range    = (regno >= GPR_BASE) && (regno < GPR_LIMIT);
  assign bad_fields  = (exec_word[31:24] != 8'd0) || (exec_word[22:20] != 3'd2) ||
                       exec_word[19] || exec_word[18];
  assign unused_bits = exec_word[23];

  assign dmi_resp_valid = resp_valid_q;
  assign dmi_resp_rdata = resp_rdata_q;
  assign dm_wara        = dm_wara_q;

  // command decode: error checks in priority order, otherwise launch the transfer
  always_comb begin
    err_set   = 3'd0;
    launch    = 1'b0;
    launch_wr = exec_word[16];
    if (exec_go) begin
      if (busy) begin
        if (cmderr_q == 3'd0) err_set = 3'd1;
      end else if (cmderr_q != 3'd0) begin
        err_set = 3'd0;
      end else if (bad_fields) begin
        err_set = 3'd2;
      end else if (exec_word[17] && !in_range) begin
        err_set = 3'd2;
      end else if (!hart_halted) begin
        err_set = 3'd4;
      end else if (exec_word[17]) begin
        launch = 1'b1;
      end
    end
  end

  // next-state: every access spends exactly one cycle in READ or WRITE
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (launch) state_d = launch_wr ? S_WRITE : S_READ;
      S_READ:  state_d = S_IDLE;
      S_WRITE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // regfile port outputs: write strobe and data only while in WRITE
  always_comb begin
    dm_wen = 1'b0;
    dm_wd  = '0;
    if (state_q == S_WRITE) begin
      dm_wen = 1'b1;
      dm_wd  = data0_q;
    end
  end

  // DMI read mux, response capture and DM register updates
  always_comb begin
    rdata_mux = '0;
    case (dmi_req_addr)
      ADDR_DATA0: rdata_mux = data0_q;
      ADDR_ACS: begin
        rdata_mux[12]   = busy;
        rdata_mux[10:8] = cmderr_q;
        rdata_mux[3:0]  = 4'd1;
      end
`ifdef DM_AUTOEXEC_EN
      ADDR_AUTO:  rdata_mux[0] = autoexec_q;
`endif
      default:    rdata_mux = '0;
    endcase

    resp_valid_d = resp_valid_q;
    resp_rdata_d = resp_rdata_q;
    if (req_fire) begin
      resp_valid_d = 1'b1;
      resp_rdata_d = dmi_req_wr ? '0 : rdata_mux;
    end else if (resp_valid_q && dmi_resp_ready) begin
      resp_valid_d = 1'b0;
    end

    data0_d = data0_q;
    if (wr_data0 && !busy) data0_d = dmi_req_wdata;
    if (state_q == S_READ) data0_d = dm_rd;

    cmderr_d = cmderr_q;
    if (wr_acs) cmderr_d = cmderr_q & ~dmi_req_wdata[10:8];
    // data0 touched while busy (reads only matter when they would re-execute)
    if (busy && (wr_data0 || (auto_on && rd_data0)) && (cmderr_q == 3'd0))
      cmderr_d = 3'd1;
    if (err_set != 3'd0) cmderr_d = err_set;

    dm_wara_d = launch ? exec_word[AW-1:0] : dm_wara_q;

`ifdef DM_AUTOEXEC_EN
    autoexec_d = wr_auto ? dmi_req_wdata[0] : autoexec_q;
    cmd_d      = (wr_cmd && !busy) ? dmi_req_wdata : cmd_q;
    pend_d     = autoexec_q && (rd_data0 || wr_data0) && !busy;
`endif
  end

  // state registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!nreset) begin
      state_q      <= S_IDLE;
      data0_q      <= '0;
      cmderr_q     <= 3'd0;
      resp_valid_q <= 1'b0;
      resp_rdata_q <= '0;
      dm_wara_q    <= '0;
`ifdef DM_AUTOEXEC_EN
      autoexec_q   <= 1'b0;
      cmd_q        <= '0;
      pend_q       <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      data0_q      <= data0_d;
      cmderr_q     <= cmderr_d;
      resp_valid_q <= resp_valid_d;
      resp_rdata_q <= resp_rdata_d;
      dm_wara_q    <= dm_wara_d;
`ifdef DM_AUTOEXEC_EN
      autoexec_q   <= autoexec_d;
      cmd_q        <= cmd_d;
      pend_q       <= pend_d;
`endif
    end
  end

endmodule

// File: doc/raifes_dm_regaccess.md
Name: raifes_dm_regaccess

Overview:
- Debug-module-side initiator for the register file's debug port.
- Decodes DMI accesses to data0, abstractcs and command, and executes RISC-V "Access Register" abstract commands.
- Drives dm_wara/dm_wd/dm_wen and samples dm_rd.
- Sits between the DMI transport and the core register file; the hart must be halted for an access.

Parameters:
- XLEN, 32, data width; equals `XPR_LEN.
- NUM_GPR, 32, implemented GPR count; 16 for E-configuration cores.
- AW, 5, width of dm_wara; equals `REG_ADDR_WIDTH.

Ports:
- clk  input  1  core clock
- nreset  input  1  synchronous active-low reset
- dmi_req_valid  input  1  DMI request present
- dmi_req_ready  output  1  request accepted when valid&ready
- dmi_req_addr  input  7  DM register address
- dmi_req_wr  input  1  1=write, 0=read
- dmi_req_wdata  input  XLEN  write data
- dmi_resp_valid  output  1  response available
- dmi_resp_ready  input  1  response consumed when valid&ready
- dmi_resp_rdata  output  XLEN  read data (0 for writes)
- hart_halted  input  1  core is in debug halt
- dm_wara  output  AW  regfile debug address
- dm_wd  output  XLEN  regfile debug write data
- dm_wen  output  1  regfile debug write strobe
- dm_rd  input  XLEN  regfile debug read data (combinational from dm_wara)

Behaviour:
- Reset (nreset=0 at posedge clk): dmi_req_ready=1, dmi_resp_valid=0, dmi_resp_rdata=0, data0=0, cmderr=0, busy=0, dm_wen=0, dm_wara=0, dm_wd=0, FSM=IDLE. Reset mid-command aborts it; no dm_wen pulse is issued after reset.
- DMI handshake:
  - dmi_req_ready = !dmi_resp_valid.
  - Accepted request in cycle N gives dmi_resp_valid=1 from N+1, held with stable rdata until dmi_resp_ready.
  - Back-to-back: the next request is accepted in the cycle after the response handshake.
- Register map:
  - 0x04 data0: R/W. A write while busy is ignored and sets cmderr=1 if cmderr==0.
  - 0x16 abstractcs: read returns progbufsize[28:24]=0, busy[12], cmderr[10:8], datacount[3:0]=1. Writes to cmderr[10:8] are write-1-to-clear per bit; other bits are read-only.
  - 0x17 command: write-only, reads 0. Other addresses read 0, writes ignored.
- Command write decode, evaluated in priority order:
  - busy=1: set cmderr=1 if cmderr==0; command dropped.
  - cmderr!=0: command dropped silently.
  - cmdtype[31:24]!=0, aarsize[22:20]!=2, aarpostincrement[19]=1, or postexec[18]=1: cmderr=2.
  - transfer[17]=1 with regno[15:0] outside 0x1000..0x1000+NUM_GPR-1: cmderr=2.
  - hart_halted=0: cmderr=4.
  - transfer=0: completes as a no-op with no busy cycle.
  - Otherwise: busy=1 at N+1, FSM to READ (write[16]=0) or WRITE (write[16]=1).
- FSM IDLE→READ→IDLE:
  - In READ (cycle N+1), dm_wara=regno[AW-1:0].
  - data0 captures dm_rd at end of N+1; busy clears at N+2.
  - regno 0x1000 (x0) yields 0 from the regfile.
- FSM IDLE→WRITE→IDLE:
  - In WRITE (cycle N+1), dm_wara=regno[AW-1:0], dm_wd=data0, dm_wen=1 for exactly one cycle.
  - busy clears at N+2. A write to x0 is issued; the regfile ignores it on read.
- dm_wen is 0 in every cycle other than WRITE. dm_wara holds its last value when idle.
- A DMI read of abstractcs in the same cycle busy falls returns the pre-edge value (busy=1).
- hart_halted falling during READ/WRITE does not abort the command; it completes normally.

Optional Feature:
- Macro: DM_AUTOEXEC_EN.
- Defined:
  - Adds abstractauto at 0x18, with autoexecdata[0] R/W (reset 0) and other bits reading 0.
  - With autoexecdata[0]=1, any accepted data0 read or write re-executes the last accepted command word, stored internally, after the data0 access completes.
  - For writes, data0 updates first. For reads, the DMI response returns data0 before re-execution.
  - The same error rules apply; a busy collision sets cmderr=1.
- Undefined: 0x18 reads 0, writes ignored, and no command word is stored.

Test Plan:
- Halted; write data0=0xDEADBEEF; write command=0x00231005 (write x5) -> dm_wen=1 one cycle, dm_wara=5, dm_wd=0xDEADBEEF; busy 1 then 0.
- Halted; command=0x00221005 with regfile x5=0x12345678 -> dm_wen stays 0; data0 read returns 0x12345678.
- hart_halted=0; command=0x00221005 -> no regfile access; abstractcs cmderr=4; writing 0x700 to abstractcs clears cmderr to 0.
- command=0x00321005 (aarsize=3) and NUM_GPR=16 with regno=0x1010 -> cmderr=2 in each case, dm_wen never 1.
- Command write in the cycle after a valid command (busy=1) -> cmderr=1, second command ignored; data0 write while busy ignored.
- DM_AUTOEXEC_EN: abstractauto=1, last command=read x3 (x3=0xA5), then read data0 -> response returns old data0, after which data0=0xA5.
